// File: rtl/wb_writeback_unit_if.sv
// Bus between MEM and the write-back stage: incoming MEM instruction,
// stall/flush control, registered WB result bus, register file read ports
// and the retired-instruction counter.
interface wb_writeback_unit_if #(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned bitwidth            = 32
);
  logic                           MEM_valid;
  logic [3:0]                     MEM_opcode;
  logic [REG_INDEX_BIT_WIDTH-1:0] MEM_index;
  logic [bitwidth-1:0]            MEM_data;
  logic                           stall;
  logic                           flush;
  logic                           WB_valid;
  logic [3:0]                     WB_opcode;
  logic [REG_INDEX_BIT_WIDTH-1:0] WB_index;
  logic [bitwidth-1:0]            WB_data;
  logic                           WB_we;
  logic [REG_INDEX_BIT_WIDTH-1:0] rd_index_a;
  logic [REG_INDEX_BIT_WIDTH-1:0] rd_index_b;
  logic [bitwidth-1:0]            rd_data_a;
  logic [bitwidth-1:0]            rd_data_b;
  logic [31:0]                    retire_count;

  // Upstream side: drives the MEM instruction, pipeline control and read addresses.
  modport master (
    output MEM_valid, MEM_opcode, MEM_index, MEM_data, stall, flush,
           rd_index_a, rd_index_b,
    input  WB_valid, WB_opcode, WB_index, WB_data, WB_we,
           rd_data_a, rd_data_b, retire_count
  );

  // Write-back stage side.
  modport slave (
    input  MEM_valid, MEM_opcode, MEM_index, MEM_data, stall, flush,
           rd_index_a, rd_index_b,
    output WB_valid, WB_opcode, WB_index, WB_data, WB_we,
           rd_data_a, rd_data_b, retire_count
  );
endinterface

// File: rtl/wb_writeback_unit.sv
// Write-back stage: WB pipeline register, 2^REG_INDEX_BIT_WIDTH x bitwidth
// register file with two combinational read ports, and a retired-instruction
// counter.
// Optional macro WB_BYPASS_EN: read ports return WB_data when the addressed
// register is being written on the coming edge (write-through reads).
module wb_writeback_unit #(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned bitwidth            = 32
) (
  input logic              clk,
  input logic              rst,
  wb_writeback_unit_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** REG_INDEX_BIT_WIDTH;

  typedef enum logic [3:0] {
    OP_NOP    = 4'b0000,
    OP_BRANCH = 4'b0010,
    OP_SW     = 4'b0011
  } opcode_e;

  logic                           wb_valid_q;
  logic [3:0]                     wb_opcode_q;
  logic [REG_INDEX_BIT_WIDTH-1:0] wb_index_q;
  logic [bitwidth-1:0]            wb_data_q;
  logic [31:0]                    retire_q;
  logic [bitwidth-1:0]            regfile [DEPTH];

  logic advance;
  logic wb_we;

  // Pipeline advance control and write-enable class decode of the WB instruction.
  always_comb begin
    advance = bus.flush | ~bus.stall;
    wb_we   = wb_valid_q &&
              !((wb_opcode_q == OP_NOP) || (wb_opcode_q == OP_BRANCH) ||
                (wb_opcode_q == OP_SW));
  end

  // WB register, register file commit and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q  <= 1'b0;
      wb_opcode_q <= OP_NOP;
      wb_index_q  <= '0;
      wb_data_q   <= '0;
      retire_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regfile[i[REG_INDEX_BIT_WIDTH-1:0]] <= '0;
      end
    end else if (advance) begin
      // The instruction already in WB commits even when flush squashes the incoming one.
      if (wb_we) begin
        regfile[wb_index_q] <= wb_data_q;
      end
      if (wb_valid_q) begin
        retire_q <= retire_q + 32'd1;
      end
      if (bus.flush || !bus.MEM_valid) begin
        wb_valid_q  <= 1'b0;
        wb_opcode_q <= OP_NOP;
        wb_index_q  <= '0;
        wb_data_q   <= '0;
      end else begin
        wb_valid_q  <= 1'b1;
        wb_opcode_q <= bus.MEM_opcode;
        wb_index_q  <= bus.MEM_index;
        wb_data_q   <= bus.MEM_data;
      end
    end
  end

  // Register file read ports, optionally write-through in the commit cycle.
  always_comb begin
    bus.rd_data_a = regfile[bus.rd_index_a];
    bus.rd_data_b = regfile[bus.rd_index_b];
`ifdef WB_BYPASS_EN
    if (advance && wb_we && (bus.rd_index_a == wb_index_q)) begin
      bus.rd_data_a = wb_data_q;
    end
    if (advance && wb_we && (bus.rd_index_b == wb_index_q)) begin
      bus.rd_data_b = wb_data_q;
    end
`endif
  end

  // Result bus toward the forwarding unit and the counter output.
  always_comb begin
    bus.WB_valid     = wb_valid_q;
    bus.WB_opcode    = wb_opcode_q;
    bus.WB_index     = wb_index_q;
    bus.WB_data      = wb_data_q;
    bus.WB_we        = wb_we;
    bus.retire_count = retire_q;
  end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed bench for wb_writeback_unit: reset sweep of the register file,
// a table of per-cycle vectors with expected state after each edge, and
// hand sequences for counter wrap and mid-operation reset.
module tb_wb_writeback_unit;

  localparam logic [3:0] ADD = 4'hC;
  localparam logic [3:0] BR  = 4'h2;
  localparam logic [3:0] SW  = 4'h3;
  localparam logic [3:0] NOP = 4'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_writeback_unit_if #(.REG_INDEX_BIT_WIDTH(4), .bitwidth(32)) bus ();

  wb_writeback_unit #(.REG_INDEX_BIT_WIDTH(4), .bitwidth(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        mv;
    logic [3:0]  mop;
    logic [3:0]  midx;
    logic [31:0] mdata;
    logic        stall;
    logic        flush;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        ev;
    logic [3:0]  eop;
    logic        ewe;
    logic [3:0]  eidx;
    logic [31:0] edata;
    logic [31:0] era;
    logic [31:0] erb;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(logic mv, logic [3:0] mop, logic [3:0] midx, logic [31:0] mdata,
                              logic stall, logic flush, logic [3:0] ra, logic [3:0] rb,
                              logic ev, logic [3:0] eop, logic ewe, logic [3:0] eidx,
                              logic [31:0] edata, logic [31:0] era, logic [31:0] erb,
                              logic [31:0] ecnt);
    mk = '{mv, mop, midx, mdata, stall, flush, ra, rb, ev, eop, ewe, eidx, edata, era, erb, ecnt};
  endfunction

  // Expected read data: array value, or the WB result when write-through applies.
  function automatic logic [31:0] exp_rd(vec_t v, logic [3:0] idx, logic [31:0] arr);
    exp_rd = arr;
`ifdef WB_BYPASS_EN
    if ((!v.stall || v.flush) && v.ewe && (idx == v.eidx)) exp_rd = v.edata;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic mv, logic [3:0] mop, logic [3:0] midx, logic [31:0] mdata,
                       logic stall, logic flush);
    bus.MEM_valid  = mv;
    bus.MEM_opcode = mop;
    bus.MEM_index  = midx;
    bus.MEM_data   = mdata;
    bus.stall      = stall;
    bus.flush      = flush;
  endtask

  initial begin
    drive(1'b0, NOP, 4'd0, 32'd0, 1'b0, 1'b0);
    bus.rd_index_a = '0;
    bus.rd_index_b = '0;

    vecs[0]  = mk(1, ADD, 2, 32'h2,  0, 0, 2, 0, 1, ADD, 1, 2, 32'h2,  32'h0,  32'h0,  0);
    vecs[1]  = mk(0, NOP, 0, 32'h0,  0, 0, 2, 0, 0, NOP, 0, 0, 32'h0,  32'h2,  32'h0,  1);
    vecs[2]  = mk(1, BR,  0, 32'h2,  0, 0, 0, 2, 1, BR,  0, 0, 32'h2,  32'h0,  32'h2,  1);
    vecs[3]  = mk(1, SW,  0, 32'h2,  0, 0, 0, 2, 1, SW,  0, 0, 32'h2,  32'h0,  32'h2,  2);
    vecs[4]  = mk(1, ADD, 5, 32'h7,  0, 0, 5, 0, 1, ADD, 1, 5, 32'h7,  32'h0,  32'h0,  3);
    vecs[5]  = mk(1, ADD, 6, 32'h9,  1, 0, 5, 6, 1, ADD, 1, 5, 32'h7,  32'h0,  32'h0,  3);
    vecs[6]  = mk(1, ADD, 6, 32'h9,  1, 0, 5, 6, 1, ADD, 1, 5, 32'h7,  32'h0,  32'h0,  3);
    vecs[7]  = mk(1, ADD, 6, 32'h9,  1, 0, 5, 6, 1, ADD, 1, 5, 32'h7,  32'h0,  32'h0,  3);
    vecs[8]  = mk(0, NOP, 0, 32'h0,  0, 0, 5, 6, 0, NOP, 0, 0, 32'h0,  32'h7,  32'h0,  4);
    vecs[9]  = mk(1, ADD, 1, 32'h11, 0, 0, 1, 3, 1, ADD, 1, 1, 32'h11, 32'h0,  32'h0,  4);
    vecs[10] = mk(1, ADD, 3, 32'h33, 1, 1, 1, 3, 0, NOP, 0, 0, 32'h0,  32'h11, 32'h0,  5);
    vecs[11] = mk(0, NOP, 0, 32'h0,  0, 0, 1, 3, 0, NOP, 0, 0, 32'h0,  32'h11, 32'h0,  5);
    vecs[12] = mk(1, ADD, 4, 32'hA,  0, 0, 4, 1, 1, ADD, 1, 4, 32'hA,  32'h0,  32'h11, 5);
    vecs[13] = mk(1, ADD, 4, 32'hB,  0, 0, 4, 1, 1, ADD, 1, 4, 32'hB,  32'hA,  32'h11, 6);
    vecs[14] = mk(0, NOP, 0, 32'h0,  0, 0, 4, 1, 0, NOP, 0, 0, 32'h0,  32'hB,  32'h11, 7);
    vecs[15] = mk(1, 4'h1, 9, 32'h99, 0, 0, 9, 4, 1, 4'h1, 1, 9, 32'h99, 32'h0, 32'hB,  7);
    vecs[16] = mk(0, NOP, 0, 32'h0,  0, 0, 9, 4, 0, NOP, 0, 0, 32'h0,  32'h99, 32'hB,  8);
    vecs[17] = mk(1, ADD, 0, 32'h5A, 0, 0, 0, 9, 1, ADD, 1, 0, 32'h5A, 32'h0,  32'h99, 8);
    vecs[18] = mk(0, NOP, 0, 32'h0,  0, 0, 0, 9, 0, NOP, 0, 0, 32'h0,  32'h5A, 32'h99, 9);

    // Reset, with stall and flush asserted to show reset wins.
    drive(1'b1, ADD, 4'd7, 32'hDEAD, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, NOP, 4'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check("rst_wb_valid", {31'd0, bus.WB_valid}, 32'd0);
    check("rst_wb_we", {31'd0, bus.WB_we}, 32'd0);
    check("rst_wb_opcode", {28'd0, bus.WB_opcode}, 32'd0);
    check("rst_wb_index_data", bus.WB_data | {28'd0, bus.WB_index}, 32'd0);
    check("rst_count", bus.retire_count, 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.rd_index_a = 4'(i);
      bus.rd_index_b = 4'(15 - i);
      #1;
      check($sformatf("rst_rd_a[%0d]", i), bus.rd_data_a, 32'd0);
      check($sformatf("rst_rd_b[%0d]", 15 - i), bus.rd_data_b, 32'd0);
    end

    // Table vectors: inputs applied at negedge, state checked after the next posedge.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].mv, vecs[i].mop, vecs[i].midx, vecs[i].mdata, vecs[i].stall, vecs[i].flush);
      bus.rd_index_a = vecs[i].ra;
      bus.rd_index_b = vecs[i].rb;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wb_valid", i), {31'd0, bus.WB_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d_wb_opcode", i), {28'd0, bus.WB_opcode}, {28'd0, vecs[i].eop});
      check($sformatf("v%0d_wb_we", i), {31'd0, bus.WB_we}, {31'd0, vecs[i].ewe});
      check($sformatf("v%0d_wb_index", i), {28'd0, bus.WB_index}, {28'd0, vecs[i].eidx});
      check($sformatf("v%0d_wb_data", i), bus.WB_data, vecs[i].edata);
      check($sformatf("v%0d_rd_a", i), bus.rd_data_a, exp_rd(vecs[i], vecs[i].ra, vecs[i].era));
      check($sformatf("v%0d_rd_b", i), bus.rd_data_b, exp_rd(vecs[i], vecs[i].rb, vecs[i].erb));
      check($sformatf("v%0d_count", i), bus.retire_count, vecs[i].ecnt);
    end

    // Counter wrap: preload all-ones, then retire one ADD into register 7.
    @(negedge clk);
    drive(1'b1, ADD, 4'd7, 32'h5, 1'b0, 1'b0);
    bus.rd_index_a = 4'd7;
    bus.rd_index_b = 4'd0;
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    @(posedge clk);
    #1;
    check("wrap_preload_count", bus.retire_count, 32'hFFFF_FFFF);
    check("wrap_rd7_before", bus.rd_data_a, exp_rd(mk(1, ADD, 7, 32'h5, 0, 0, 7, 0, 1, ADD, 1, 7, 32'h5, 32'h0, 32'h0, 0), 4'd7, 32'h0));
    @(negedge clk);
    drive(1'b0, NOP, 4'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("wrap_count_zero", bus.retire_count, 32'd0);
    check("wrap_rd7_after", bus.rd_data_a, 32'h5);

    // Reset mid-operation: the ADD sitting in WB must be discarded uncommitted.
    @(negedge clk);
    drive(1'b1, ADD, 4'd8, 32'h88, 1'b0, 1'b0);
    bus.rd_index_a = 4'd8;
    bus.rd_index_b = 4'd2;
    @(posedge clk);
    #1;
    check("midrst_wb_index", {28'd0, bus.WB_index}, 32'd8);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, NOP, 4'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("midrst_wb_valid", {31'd0, bus.WB_valid}, 32'd0);
    check("midrst_count", bus.retire_count, 32'd0);
    check("midrst_rd_b_cleared", bus.rd_data_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_rd8_never_written", bus.rd_data_a, 32'd0);
    check("midrst_count_idle", bus.retire_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
